// File: rtl/mean_estimator.sv
`default_nettype none
// ============================================================================
// Module      : mean_estimator
// Description : Per-channel block mean of 2**LOG2N signed samples on four
//               channels; feeds the centering subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module mean_estimator #(
    parameter int DW    = 26,
    parameter int LOG2N = 10,
    parameter int ACCW  = DW + LOG2N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x1_in,
    input  logic signed [DW-1:0] x2_in,
    input  logic signed [DW-1:0] x3_in,
    input  logic signed [DW-1:0] x4_in,
    output logic signed [DW-1:0] mean1,
    output logic signed [DW-1:0] mean2,
    output logic signed [DW-1:0] mean3,
    output logic signed [DW-1:0] mean4,
    output logic                 mean_valid,
    output logic                 busy,
    output logic [LOG2N-1:0]     sample_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam logic [LOG2N-1:0] c_CNT_LAST = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [LOG2N-1:0]   r_sample_cnt;
    logic               r_mean_valid;
    logic               w_clear;
    logic               w_accept;
    logic               w_last;
    logic [3:0][DW-1:0] w_x;
    logic [3:0][DW-1:0] w_mean;

    assign w_x      = {x4_in, x3_in, x2_in, x1_in};
    assign w_clear  = (r_state == S_IDLE) && start;
    assign w_accept = (r_state == S_ACC) && in_valid;
    assign w_last   = w_accept && (r_sample_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_ACC;
            S_ACC:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_mean_valid <= 1'b0;
        end else begin
            r_mean_valid <= w_last;
            if (w_clear || w_last) begin
                r_sample_cnt <= '0;
            end else if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    // The mean is bits [LOG2N +: DW] of the final sum, i.e. an arithmetic
    // right shift by LOG2N (floor toward -inf) truncated to DW bits.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_ch
            logic [ACCW-1:0] r_acc;
            logic [DW-1:0]   r_mean;
            logic [ACCW-1:0] w_sum;

            assign w_sum = r_acc + {{(ACCW-DW){w_x[k][DW-1]}}, w_x[k]};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc  <= '0;
                    r_mean <= '0;
                end else begin
                    if (w_clear) begin
                        r_acc <= '0;
                    end else if (w_accept) begin
                        r_acc <= w_sum;
                    end
                    if (w_last) begin
                        r_mean <= w_sum[LOG2N +: DW];
                    end
                end
            end

            assign w_mean[k] = r_mean;
        end
    endgenerate

    assign mean1      = w_mean[0];
    assign mean2      = w_mean[1];
    assign mean3      = w_mean[2];
    assign mean4      = w_mean[3];
    assign mean_valid = r_mean_valid;
    assign sample_cnt = r_sample_cnt;
    assign in_ready   = (r_state == S_ACC);
    assign busy       = (r_state == S_ACC);

endmodule
`default_nettype wire

// File: tb/tb_mean_estimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mean_estimator
// Description : Directed self-checking bench for mean_estimator (N = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mean_estimator;

    localparam int DW    = 26;
    localparam int LOG2N = 2;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x1_in, x2_in, x3_in, x4_in;
    logic signed [DW-1:0] mean1, mean2, mean3, mean4;
    logic                 mean_valid;
    logic                 busy;
    logic [LOG2N-1:0]     sample_cnt;

    int checks = 0;
    int fails  = 0;

    mean_estimator #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x1_in      (x1_in),
        .x2_in      (x2_in),
        .x3_in      (x3_in),
        .x4_in      (x4_in),
        .mean1      (mean1),
        .mean2      (mean2),
        .mean3      (mean3),
        .mean4      (mean4),
        .mean_valid (mean_valid),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        x1_in = a[DW-1:0];
        x2_in = b[DW-1:0];
        x3_in = c[DW-1:0];
        x4_in = d[DW-1:0];
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        in_valid = 1'b1;
        set_x(a, b, c, d);
        tick();
        in_valid = 1'b0;
        set_x(12345, -12345, 999, -999);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({mean1, mean2, mean3, mean4} !== '0) begin
            fails++;
            $display("FAIL reset_means: got %0d %0d %0d %0d, expected 0 0 0 0", mean1, mean2, mean3, mean4);
        end
        checks++;
        if ({mean_valid, in_ready, busy, sample_cnt} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: mv=%b rdy=%b busy=%b cnt=%0d, expected all 0", mean_valid, in_ready, busy, sample_cnt);
        end
    endtask

    task automatic test_constants();
        // in_valid during the start cycle must be ignored
        in_valid = 1'b1;
        set_x(999, 999, 999, 999);
        do_start();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, sample_cnt} !== 4'b1100) begin
            fails++;
            $display("FAIL const_enter_acc: rdy=%b busy=%b cnt=%0d, expected 1 1 0", in_ready, busy, sample_cnt);
        end
        send(100, -100, 0, 7);
        send(100, -100, 0, 7);
        send(100, -100, 0, 7);
        checks++;
        if (mean_valid !== 1'b0 || sample_cnt !== 2'd3) begin
            fails++;
            $display("FAIL const_before_last: mv=%b cnt=%0d, expected 0 3", mean_valid, sample_cnt);
        end
        send(100, -100, 0, 7);
        checks++;
        if (mean_valid !== 1'b1 || in_ready !== 1'b0 || sample_cnt !== 2'd0) begin
            fails++;
            $display("FAIL const_valid: mv=%b rdy=%b cnt=%0d, expected 1 0 0", mean_valid, in_ready, sample_cnt);
        end
        checks++;
        if (mean1 !== 26'sd100 || mean2 !== -26'sd100 || mean3 !== 26'sd0 || mean4 !== 26'sd7) begin
            fails++;
            $display("FAIL const_means: got %0d %0d %0d %0d, expected 100 -100 0 7", mean1, mean2, mean3, mean4);
        end
        tick();
        checks++;
        if (mean_valid !== 1'b0 || mean1 !== 26'sd100 || mean4 !== 26'sd7) begin
            fails++;
            $display("FAIL const_pulse_hold: mv=%b m1=%0d m4=%0d, expected 0 100 7", mean_valid, mean1, mean4);
        end
    endtask

    task automatic test_floor();
        do_start();
        send(-1, 1, -5, 5);
        send(-2, 1,  0, 0);
        send( 0, 1,  0, 0);
        send( 0, 0,  0, 0);
        checks++;
        if (mean_valid !== 1'b1 || mean1 !== -26'sd1 || mean2 !== 26'sd0 || mean3 !== -26'sd2 || mean4 !== 26'sd1) begin
            fails++;
            $display("FAIL floor: mv=%b got %0d %0d %0d %0d, expected 1 -1 0 -2 1", mean_valid, mean1, mean2, mean3, mean4);
        end
        tick();
    endtask

    task automatic test_extremes();
        int mx;
        int mn;
        mx = 33554431;
        mn = -33554432;
        do_start();
        for (int i = 0; i < 4; i++) send(mx, mn, mx, mn);
        checks++;
        if (mean1 !== 26'sd33554431 || mean2 !== -26'sd33554432 || mean3 !== 26'sd33554431 || mean4 !== -26'sd33554432) begin
            fails++;
            $display("FAIL extremes: got %0d %0d %0d %0d, expected 33554431 -33554432 33554431 -33554432", mean1, mean2, mean3, mean4);
        end
        tick();
    endtask

    task automatic test_gaps();
        logic       pat [7];
        logic [1:0] exp_cnt [7];
        int         xs1 [4];
        int         xs2 [4];
        int         idx;
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        xs1     = '{10, 20, 30, 40};
        xs2     = '{-1, -1, -1, -2};
        idx     = 0;
        do_start();
        for (int c = 0; c < 7; c++) begin
            start = (c == 2);
            if (pat[c]) begin
                send(xs1[idx], xs2[idx], 0, 4);
                idx++;
            end else begin
                set_x(777, 777, 777, 777);
                tick();
            end
            start = 1'b0;
            checks++;
            if (sample_cnt !== exp_cnt[c]) begin
                fails++;
                $display("FAIL gaps_cnt[%0d]: got %0d, expected %0d", c, sample_cnt, exp_cnt[c]);
            end
        end
        checks++;
        if (mean_valid !== 1'b1 || mean1 !== 26'sd25 || mean2 !== -26'sd2 || mean3 !== 26'sd0 || mean4 !== 26'sd4) begin
            fails++;
            $display("FAIL gaps_means: mv=%b got %0d %0d %0d %0d, expected 1 25 -2 0 4", mean_valid, mean1, mean2, mean3, mean4);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_start();
        send(100, 100, 100, 100);
        send(100, 100, 100, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mean1, mean2, mean3, mean4} !== '0 || {mean_valid, in_ready, busy, sample_cnt} !== 5'b0) begin
            fails++;
            $display("FAIL rst_mid: means %0d %0d %0d %0d mv=%b rdy=%b busy=%b cnt=%0d, expected all 0",
                     mean1, mean2, mean3, mean4, mean_valid, in_ready, busy, sample_cnt);
        end
        do_start();
        for (int i = 0; i < 4; i++) send(8, 8, 8, 8);
        checks++;
        if (mean_valid !== 1'b1 || mean1 !== 26'sd8 || mean2 !== 26'sd8 || mean3 !== 26'sd8 || mean4 !== 26'sd8) begin
            fails++;
            $display("FAIL rst_mid_after: mv=%b got %0d %0d %0d %0d, expected 1 8 8 8 8", mean_valid, mean1, mean2, mean3, mean4);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < 4; i++) send(5, -5, 5, -5);
        checks++;
        if (mean_valid !== 1'b1 || mean1 !== 26'sd5 || mean2 !== -26'sd5) begin
            fails++;
            $display("FAIL b2b_first: mv=%b m1=%0d m2=%0d, expected 1 5 -5", mean_valid, mean1, mean2);
        end
        do_start();
        checks++;
        if (in_ready !== 1'b1 || mean_valid !== 1'b0 || mean1 !== 26'sd5) begin
            fails++;
            $display("FAIL b2b_restart: rdy=%b mv=%b m1=%0d, expected 1 0 5", in_ready, mean_valid, mean1);
        end
        for (int i = 0; i < 3; i++) send(3, 3, 3, 3);
        checks++;
        if (mean_valid !== 1'b0 || mean1 !== 26'sd5 || mean4 !== -26'sd5) begin
            fails++;
            $display("FAIL b2b_hold: mv=%b m1=%0d m4=%0d, expected 0 5 -5", mean_valid, mean1, mean4);
        end
        send(3, 3, 3, 3);
        checks++;
        if (mean_valid !== 1'b1 || mean1 !== 26'sd3 || mean2 !== 26'sd3 || mean3 !== 26'sd3 || mean4 !== 26'sd3) begin
            fails++;
            $display("FAIL b2b_second: mv=%b got %0d %0d %0d %0d, expected 1 3 3 3 3", mean_valid, mean1, mean2, mean3, mean4);
        end
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        set_x(0, 0, 0, 0);
        tick();
        test_reset();
        test_constants();
        test_floor();
        test_extremes();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
